// File: rtl/remote_comm_pkg.sv
// Shared constants for the Knight's Tour host link: baud rate, robot responses,
// command opcodes and the byte-sequencer state encoding.
package remote_comm_pkg;

  localparam int BAUD_DIV_DEF = 2604;

  localparam logic [7:0] POS_ACK          = 8'hA5;
  localparam logic [7:0] MOVE_IN_PROGRESS = 8'h5A;

  localparam logic [15:0] CAL_GYRO        = 16'h2000;
  localparam logic [3:0]  MOVE_OP         = 4'h4;
  localparam logic [3:0]  MOVE_FANFARE_OP = 4'h5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  // Heading occupies [11:4], square count [3:0].
  function automatic logic [15:0] move_cmd(input logic [3:0] op,
                                           input logic [7:0] heading,
                                           input logic [3:0] squares);
    return {op, heading, squares};
  endfunction

endpackage

// File: rtl/remote_comm_uart.sv
// Full-duplex 8N1 UART: a transmitter that accepts a byte on trmt and a
// receiver that centre-samples RX and flags each received byte.
module uart
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int CW = $clog2(BAUD_DIV + 1);

  logic [9:0]    tx_shft;
  logic          tx_busy;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bits;
  logic          tx_shift;

  // tx_done fires in the last clock of the stop bit so the next frame can
  // start on the very next clock with no idle gap.
  assign tx_shift = tx_busy && (tx_baud == CW'(BAUD_DIV - 1));
  assign tx_done  = tx_shift && (tx_bits == 4'd9);
  assign TX       = tx_shft[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft <= '1;
      tx_busy <= 1'b0;
      tx_baud <= '0;
      tx_bits <= '0;
    end else if (trmt) begin
      tx_shft <= {1'b1, tx_data, 1'b0};
      tx_busy <= 1'b1;
      tx_baud <= '0;
      tx_bits <= '0;
    end else if (tx_shift) begin
      tx_shft <= {1'b1, tx_shft[9:1]};
      tx_baud <= '0;
      tx_bits <= tx_bits + 4'd1;
      if (tx_bits == 4'd9) tx_busy <= 1'b0;
    end else if (tx_busy) begin
      tx_baud <= tx_baud + CW'(1);
    end
  end

  logic          rx_ff1, rx_ff2, rx_ff3;
  logic          rx_busy;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bits;
  logic [8:0]    rx_shft;
  logic          rx_sample;

  assign rx_sample = rx_busy && (rx_cnt == '0);

  // rx_ff3 only serves edge detection; sampling uses the synchronized rx_ff2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ff1  <= 1'b1;
      rx_ff2  <= 1'b1;
      rx_ff3  <= 1'b1;
      rx_busy <= 1'b0;
      rx_cnt  <= '0;
      rx_bits <= '0;
      rx_rdy  <= 1'b0;
      rx_data <= '0;
    end else begin
      rx_ff1 <= RX;
      rx_ff2 <= rx_ff1;
      rx_ff3 <= rx_ff2;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy && rx_ff3 && !rx_ff2) begin
        rx_busy <= 1'b1;
        rx_cnt  <= CW'(BAUD_DIV / 2 - 1);
        rx_bits <= '0;
        rx_rdy  <= 1'b0;
      end else if (rx_sample) begin
        rx_cnt  <= CW'(BAUD_DIV - 1);
        rx_bits <= rx_bits + 4'd1;
        if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          rx_data <= rx_shft[8:1];
          rx_rdy  <= 1'b1;
        end
      end else if (rx_busy) begin
        rx_cnt <= rx_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_sample) rx_shft <= {rx_ff2, rx_shft[8:1]};
  end

endmodule

// File: rtl/remote_comm.sv
// Host-side command link: sends a 16-bit command as two back-to-back UART
// bytes (high first) and reports single-byte robot responses.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  logic [1:0] state, nxt_state;
  logic [7:0] low_byte;
  logic [7:0] tx_data;
  logic       trmt, tx_done;
  logic       set_snt, clr_snt;

  always_comb begin
    nxt_state = state;
    trmt      = 1'b0;
    tx_data   = cmd[15:8];
    set_snt   = 1'b0;
    clr_snt   = 1'b0;
    case (state)
      ST_IDLE: if (snd_cmd) begin
        trmt      = 1'b1;
        clr_snt   = 1'b1;
        nxt_state = ST_HIGH;
      end
      ST_HIGH: if (tx_done) begin
        trmt      = 1'b1;
        tx_data   = low_byte;
        nxt_state = ST_LOW;
      end
      ST_LOW: if (tx_done) begin
        set_snt   = 1'b1;
        nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cmd_snt <= 1'b0;
    end else begin
      state <= nxt_state;
      if (clr_snt) cmd_snt <= 1'b0;
      else if (set_snt) cmd_snt <= 1'b1;
    end
  end

  // Captured only on acceptance so later changes to cmd cannot corrupt the low byte.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && snd_cmd) low_byte <= cmd[7:0];
  end

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .TX        (TX),
    .RX        (RX),
    .clr_rx_rdy(1'b0),
    .rx_rdy    (resp_rdy),
    .rx_data   (resp)
  );

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at a short baud divisor: decodes TX with a
// bench receiver and drives hand-built frames on RX.
module tb_remote_comm;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int n_cmp = 0;
  int n_bad = 0;

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .cmd     (cmd),
    .snd_cmd (snd_cmd),
    .cmd_snt (cmd_snt),
    .resp_rdy(resp_rdy),
    .resp    (resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench receiver: waits (bounded) for a start bit, samples mid-bit.
  task automatic uart_get(output logic [7:0] b, output logic stop, output bit ok);
    ok = 1'b0;
    b = 8'h00;
    stop = 1'b0;
    for (int i = 0; i < 40 * B; i++) begin
      tick();
      if (TX === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) return;
    repeat (B / 2) tick();
    if (TX !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (B) tick();
      b[i] = TX;
    end
    repeat (B) tick();
    stop = TX;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    RX = 1'b0;
    repeat (B) tick();
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (B) tick();
    end
    RX = stop;
    repeat (B) tick();
    RX = 1'b1;
  endtask

  task automatic test_reset();
    int bad_tx, bad_snt, bad_rdy;
    bad_tx = 0; bad_snt = 0; bad_rdy = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (TX !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", TX); end
    n_cmp++; if (cmd_snt !== 1'b0) begin n_bad++; $display("FAIL reset_cmd_snt: got %b want 0", cmd_snt); end
    n_cmp++; if (resp_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_resp_rdy: got %b want 0", resp_rdy); end
    n_cmp++; if (resp !== 8'h00) begin n_bad++; $display("FAIL reset_resp: got %h want 00", resp); end
    rst_n = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (TX !== 1'b1) bad_tx++;
      if (cmd_snt !== 1'b0) bad_snt++;
      if (resp_rdy !== 1'b0) bad_rdy++;
    end
    n_cmp++; if (bad_tx != 0) begin n_bad++; $display("FAIL idle_tx: %0d cycles not high, want 0", bad_tx); end
    n_cmp++; if (bad_snt != 0) begin n_bad++; $display("FAIL idle_cmd_snt: %0d cycles high, want 0", bad_snt); end
    n_cmp++; if (bad_rdy != 0) begin n_bad++; $display("FAIL idle_resp_rdy: %0d cycles high, want 0", bad_rdy); end
  endtask

  task automatic test_tx_cmd();
    logic [7:0] b0, b1;
    logic s0, s1;
    bit ok0, ok1, got;
    int cnt;
    tick();
    cmd = 16'h4002;
    snd_cmd = 1'b1;
    fork
      begin
        cnt = 0; got = 1'b0;
        for (int i = 0; i < 25 * B; i++) begin
          tick();
          cnt++;
          if (i == 0) snd_cmd = 1'b0;
          if (cmd_snt === 1'b1) begin got = 1'b1; break; end
        end
      end
      begin
        uart_get(b0, s0, ok0);
        uart_get(b1, s1, ok1);
      end
    join
    n_cmp++; if (!(ok0 && ok1)) begin n_bad++; $display("FAIL tx_frames_seen: got %b%b want 11", ok0, ok1); end
    n_cmp++; if (b0 !== 8'h40) begin n_bad++; $display("FAIL tx_high_byte: got %h want 40", b0); end
    n_cmp++; if (b1 !== 8'h02) begin n_bad++; $display("FAIL tx_low_byte: got %h want 02", b1); end
    n_cmp++; if ({s0, s1} !== 2'b11) begin n_bad++; $display("FAIL tx_stop_bits: got %b want 11", {s0, s1}); end
    n_cmp++; if (!got || cnt != 20 * B + 1) begin n_bad++; $display("FAIL cmd_snt_latency: got %0d (seen %b) want %0d", cnt, got, 20 * B + 1); end
    n_cmp++; if (TX !== 1'b1) begin n_bad++; $display("FAIL tx_idle_after: got %b want 1", TX); end
  endtask

  task automatic test_rx_resp();
    int cnt;
    tick();
    fork
      send_rx(8'hA5, 1'b1);
      begin
        cnt = 0;
        for (int i = 0; i < 12 * B; i++) begin
          tick();
          cnt++;
          if (resp_rdy === 1'b1) break;
        end
      end
    join
    n_cmp++; if (cnt < 19 * B / 2 + 2 || cnt > 19 * B / 2 + 4) begin n_bad++; $display("FAIL rx_rdy_latency: got %0d want %0d", cnt, 19 * B / 2 + 3); end
    n_cmp++; if (resp !== 8'hA5) begin n_bad++; $display("FAIL rx_resp_a5: got %h want a5", resp); end
    repeat (50) tick();
    n_cmp++; if (resp_rdy !== 1'b1) begin n_bad++; $display("FAIL rx_rdy_held: got %b want 1", resp_rdy); end
    n_cmp++; if (resp !== 8'hA5) begin n_bad++; $display("FAIL rx_resp_held: got %h want a5", resp); end
    // Bad stop bit: byte must still be delivered.
    fork
      send_rx(8'h3C, 1'b0);
      begin
        repeat (6) tick();
        n_cmp++; if (resp_rdy !== 1'b0) begin n_bad++; $display("FAIL rx_rdy_clr_on_start: got %b want 0", resp_rdy); end
      end
    join
    n_cmp++; if (resp_rdy !== 1'b1) begin n_bad++; $display("FAIL rx_rdy_bad_stop: got %b want 1", resp_rdy); end
    n_cmp++; if (resp !== 8'h3C) begin n_bad++; $display("FAIL rx_resp_bad_stop: got %h want 3c", resp); end
    repeat (2 * B) tick();
  endtask

  task automatic test_ignore_mid();
    logic [7:0] b0, b1, b2;
    logic s0, s1, s2;
    bit ok0, ok1, ok2;
    tick();
    cmd = 16'h47F1;
    snd_cmd = 1'b1;
    fork
      begin
        for (int i = 0; i < 25 * B; i++) begin
          tick();
          if (i == 0) begin
            snd_cmd = 1'b0;
            n_cmp++; if (cmd_snt !== 1'b0) begin n_bad++; $display("FAIL cmd_snt_cleared: got %b want 0", cmd_snt); end
          end
          if (i == 3 * B) begin cmd = 16'h5BF1; snd_cmd = 1'b1; end
          if (i == 3 * B + 1) begin snd_cmd = 1'b0; cmd = 16'hFFFF; end
          if (cmd_snt === 1'b1) break;
        end
      end
      begin
        uart_get(b0, s0, ok0);
        uart_get(b1, s1, ok1);
      end
    join
    n_cmp++; if (!(ok0 && ok1) || b0 !== 8'h47) begin n_bad++; $display("FAIL ignore_high_byte: got %h want 47", b0); end
    n_cmp++; if (b1 !== 8'hF1) begin n_bad++; $display("FAIL ignore_low_byte: got %h want f1", b1); end
    n_cmp++; if (cmd_snt !== 1'b1) begin n_bad++; $display("FAIL ignore_cmd_snt: got %b want 1", cmd_snt); end
    uart_get(b2, s2, ok2);
    n_cmp++; if (ok2) begin n_bad++; $display("FAIL ignore_no_third_frame: got frame %h want none", b2); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] b0, b1;
    logic s0, s1;
    bit ok0, ok1, got;
    tick();
    cmd = 16'h53F2;
    snd_cmd = 1'b1;
    fork
      begin tick(); snd_cmd = 1'b0; end
      begin uart_get(b0, s0, ok0); uart_get(b1, s1, ok1); end
      send_rx(8'h5A, 1'b1);
    join
    got = 1'b0;
    for (int i = 0; i < 4 * B; i++) begin
      if (cmd_snt === 1'b1) begin got = 1'b1; break; end
      tick();
    end
    n_cmp++; if (!(ok0 && ok1) || {b0, b1} !== 16'h53F2) begin n_bad++; $display("FAIL simul_tx: got %h%h want 53f2", b0, b1); end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL simul_cmd_snt: got %b want 1", cmd_snt); end
    n_cmp++; if (resp !== 8'h5A || resp_rdy !== 1'b1) begin n_bad++; $display("FAIL simul_rx: got %h rdy %b want 5a rdy 1", resp, resp_rdy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b0, b1;
    logic s0, s1;
    bit ok0, ok1, got;
    int cnt;
    tick();
    cmd = 16'h4102;
    snd_cmd = 1'b1;
    tick();
    snd_cmd = 1'b0;
    repeat (3 * B) tick();
    n_cmp++; if (TX !== 1'b0) begin n_bad++; $display("FAIL mid_frame_bit: got %b want 0", TX); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (TX !== 1'b1) begin n_bad++; $display("FAIL async_reset_tx: got %b want 1", TX); end
    n_cmp++; if (cmd_snt !== 1'b0 || resp_rdy !== 1'b0 || resp !== 8'h00) begin n_bad++; $display("FAIL async_reset_outs: got snt %b rdy %b resp %h want 0 0 00", cmd_snt, resp_rdy, resp); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    cmd = 16'h2000;
    snd_cmd = 1'b1;
    fork
      begin
        cnt = 0; got = 1'b0;
        for (int i = 0; i < 25 * B; i++) begin
          tick();
          cnt++;
          if (i == 0) snd_cmd = 1'b0;
          if (cmd_snt === 1'b1) begin got = 1'b1; break; end
        end
      end
      begin uart_get(b0, s0, ok0); uart_get(b1, s1, ok1); end
    join
    n_cmp++; if (!(ok0 && ok1) || {b0, b1} !== 16'h2000) begin n_bad++; $display("FAIL post_reset_tx: got %h%h want 2000", b0, b1); end
    n_cmp++; if (!got || cnt != 20 * B + 1) begin n_bad++; $display("FAIL post_reset_cmd_snt: got %0d want %0d", cnt, 20 * B + 1); end
  endtask

  initial begin
    test_reset();
    test_tx_cmd();
    test_rx_resp();
    test_ignore_mid();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
